mssd_scan_ctrl: RTL

Parametrised multiplexed seven-segment scan controller; successor to the fixed 8-digit display driver in the board top level. Time-multiplexes DIGITS hex digits onto one shared active-low segment bus. Adds frame-synchronous input latching, per-digit enable, leading-zero blanking, PWM brightness and an anti-ghosting guard interval. Sits between the core's debug outputs and the board's AN/CA..CG/DP pins.

---
 rtl/mssd_scan_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous shadow latching,
// leading-zero blanking, PWM brightness and anode guard interval. Optional raw segment mode: MSSD_RAW_SEG_EN.
module mssd_scan_ctrl #(
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned TICK_DIV = 100000,
   parameter int unsigned GUARD    = 16,
   parameter int unsigned PWM_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_value,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  lz_blank,
   input  logic [PWM_BITS-1:0]   brightness,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_start
`ifdef MSSD_RAW_SEG_EN
   ,
   input  logic                  raw_mode,
   input  logic [7*DIGITS-1:0]   raw_seg
`endif
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PRE_W = $clog2(TICK_DIV);
   localparam int unsigned VAL_W = 4 * DIGITS;

   logic [PRE_W-1:0]    presc_q, presc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;

   logic [VAL_W-1:0]    val_q, val_d;
   logic [DIGITS-1:0]   dpv_q, dpv_d;
   logic [DIGITS-1:0]   en_q, en_d;
   logic                lz_q, lz_d;
   logic [PWM_BITS-1:0] bri_q, bri_d;
`ifdef MSSD_RAW_SEG_EN
   logic                raw_mode_q, raw_mode_d;
   logic [7*DIGITS-1:0] raw_seg_q, raw_seg_d;
`endif

   logic [DIGITS-1:0]   an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic                fs_q, fs_d;

   logic                load_c;
   logic                raw_sel_c;
   logic [3:0]          nib_c;
   logic [DIGITS-1:0]   blank_c;
   logic                all_zero_c;
   logic                pwm_on_c;
   logic                lit_c;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Slot prescaler, digit index, PWM counter and frame-synchronous shadow capture
   always_comb begin
      presc_d = presc_q + PRE_W'(1);
      idx_d   = idx_q;
      pwm_d   = pwm_q + PWM_BITS'(1);
      val_d   = val_q;
      dpv_d   = dpv_q;
      en_d    = en_q;
      lz_d    = lz_q;
      bri_d   = bri_q;
`ifdef MSSD_RAW_SEG_EN
      raw_mode_d = raw_mode_q;
      raw_seg_d  = raw_seg_q;
`endif
      load_c = (presc_q == '0) && (idx_q == '0);
      if (presc_q == PRE_W'(TICK_DIV - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      if (load_c) begin
         val_d = value;
         dpv_d = dp_value;
         en_d  = digit_en;
         lz_d  = lz_blank;
         bri_d = brightness;
`ifdef MSSD_RAW_SEG_EN
         raw_mode_d = raw_mode;
         raw_seg_d  = raw_seg;
`endif
      end
   end

   // Display decision uses the shadow as seen this cycle (fresh values on a load cycle)
   always_comb begin
`ifdef MSSD_RAW_SEG_EN
      raw_sel_c = raw_mode_d;
`else
      raw_sel_c = 1'b0;
`endif
      nib_c      = val_d[4*int'(idx_q) +: 4];
      blank_c    = '0;
      all_zero_c = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         all_zero_c = all_zero_c & (val_d[4*i +: 4] == 4'h0);
         blank_c[i] = lz_d & all_zero_c & ~raw_sel_c;
      end
      pwm_on_c = (pwm_q <= bri_d);
      lit_c    = en_d[idx_q] & ~blank_c[idx_q] & pwm_on_c & (presc_q >= PRE_W'(GUARD));

      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      fs_d  = load_c;
      if (lit_c) begin
         an_d[idx_q] = 1'b0;
         seg_d       = hex7(nib_c);
`ifdef MSSD_RAW_SEG_EN
         if (raw_sel_c) seg_d = raw_seg_d[7*int'(idx_q) +: 7];
`endif
         dp_d        = ~dpv_d[idx_q];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         idx_q   <= '0;
         pwm_q   <= '0;
         val_q   <= '0;
         dpv_q   <= '0;
         en_q    <= '0;
         lz_q    <= 1'b0;
         bri_q   <= '0;
`ifdef MSSD_RAW_SEG_EN
         raw_mode_q <= 1'b0;
         raw_seg_q  <= '0;
`endif
         an_q    <= '1;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         pwm_q   <= pwm_d;
         val_q   <= val_d;
         dpv_q   <= dpv_d;
         en_q    <= en_d;
         lz_q    <= lz_d;
         bri_q   <= bri_d;
`ifdef MSSD_RAW_SEG_EN
         raw_mode_q <= raw_mode_d;
         raw_seg_q  <= raw_seg_d;
`endif
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         fs_q    <= fs_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign frame_start = fs_q;

endmodule
